wdt_reset_responder: RTL

WDT_RESET_RESPONDER -- requirements
Module: wdt_reset_responder

---
 rtl/wdt_reset_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/wdt_reset_responder.sv
// wdt_reset_responder: watchdog expiry -> warning irq, grace window, held sys reset.
// Define WDT_RESP_COUNT_EN to add the saturating rst_count output.
module wdt_reset_responder #(
  parameter int GRACE_W = 16,
  parameter int HOLD_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               timeout,
  input  logic               ack,
  input  logic               clear_cause,
  input  logic [GRACE_W-1:0] grace_cycles,
  input  logic [HOLD_W-1:0]  hold_cycles,
  output logic               irq,
  output logic               sys_rst,
  output logic               busy,
  output logic               cause
`ifdef WDT_RESP_COUNT_EN
  ,
  output logic [7:0]         rst_count
`endif
);

  localparam int CW = (GRACE_W > HOLD_W) ? GRACE_W : HOLD_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARN,
    ST_HOLD,
    ST_REL
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q;
  logic          irq_q, irq_d;
  logic          sys_rst_q, sys_rst_d;
  logic          busy_q, busy_d;
  logic          cause_q, cause_d;
  logic          trig;
  logic          set_cause;

  assign trig = timeout & ~timeout_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    set_cause = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_WARN;
          cnt_d   = CW'(grace_cycles);
        end
      end
      ST_WARN: begin
        // ack beats an expiring grace count on the same edge
        if (ack) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d   = ST_HOLD;
          cnt_d     = CW'(hold_cycles);
          set_cause = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_REL;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_REL: begin
        state_d = ST_IDLE;
      end
    endcase

    irq_d     = (state_d == ST_WARN);
    sys_rst_d = (state_d == ST_HOLD);
    busy_d    = (state_d != ST_IDLE);
    cause_d   = set_cause | (cause_q & ~clear_cause);
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      irq_q     <= 1'b0;
      sys_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      cause_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout;
      irq_q     <= irq_d;
      sys_rst_q <= sys_rst_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
    end
  end

  assign irq     = irq_q;
  assign sys_rst = sys_rst_q;
  assign busy    = busy_q;
  assign cause   = cause_q;

`ifdef WDT_RESP_COUNT_EN
  logic [7:0] rst_count_q, rst_count_d;

  always_comb begin
    rst_count_d = rst_count_q;
    if (set_cause) begin
      if (rst_count_q != 8'hFF) rst_count_d = rst_count_q + 8'd1;
    end else if (clear_cause) begin
      rst_count_d = '0;
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) rst_count_q <= '0;
    else       rst_count_q <= rst_count_d;
  end

  assign rst_count = rst_count_q;
`endif

endmodule
